// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle MIPS-like integer core with iterative multiplier
//
// Purpose: fetches 32-bit instructions over a request/ack port and executes
// add/sub/and/or/addi in one EXEC cycle and mul by shift-add over DATA_W
// cycles; op 6'h3F halts until reset.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-low reset
//   start_i      begin execution from PC 0 (sampled in IDLE only)
//   imem_req_o   instruction fetch request (FETCH state)
//   imem_addr_o  fetch byte address (current PC)
//   imem_ack_i   fetch data valid this cycle
//   imem_data_i  instruction word qualified by imem_ack_i
//   busy_o       high in every state except IDLE and HALT
//   halt_o       high in HALT
//   wb_en_o      one-cycle pulse per register-file write
//   wb_addr_o    register written (0 when no write)
//   wb_data_o    value written (0 when no write)
module multi_cycle_cpu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREG   = 32,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic              busy_o,
  output logic              halt_o,
  output logic              wb_en_o,
  output logic [RA_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL, S_WB, S_HALT
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic [DATA_W-1:0] r_regs [NREG];
  // r_acc holds the EXEC result or the running multiplier product
  logic [DATA_W-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  logic [5:0]        w_op, w_funct;
  logic [RA_W-1:0]   w_rs, w_rt, w_rd, w_dest;
  logic [DATA_W-1:0] w_rs_val, w_rt_val, w_imm, w_alu;
  logic              w_supported, w_is_mul, w_is_halt, w_wb_en;

  assign w_op     = r_inst[31:26];
  assign w_funct  = r_inst[5:0];
  // Only the low RA_W bits of each register field select a register
  assign w_rs     = r_inst[21 +: RA_W];
  assign w_rt     = r_inst[16 +: RA_W];
  assign w_rd     = r_inst[11 +: RA_W];
  assign w_rs_val = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_regs[w_rt];
  assign w_imm    = DATA_W'($signed(r_inst[15:0]));
  assign w_is_mul  = (w_op == 6'h00) && (w_funct == 6'h18);
  assign w_is_halt = (w_op == 6'h3F);

  always_comb begin
    w_supported = 1'b0;
    w_dest      = w_rd;
    w_alu       = '0;
    if (w_op == 6'h00) begin
      case (w_funct)
        6'h20: begin w_supported = 1'b1; w_alu = w_rs_val + w_rt_val; end
        6'h22: begin w_supported = 1'b1; w_alu = w_rs_val - w_rt_val; end
        6'h24: begin w_supported = 1'b1; w_alu = w_rs_val & w_rt_val; end
        6'h25: begin w_supported = 1'b1; w_alu = w_rs_val | w_rt_val; end
        6'h18: w_supported = 1'b1;
        default: w_supported = 1'b0;
      endcase
    end else if (w_op == 6'h08) begin
      w_supported = 1'b1;
      w_dest      = w_rt;
      w_alu       = w_rs_val + w_imm;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = S_FETCH;
      S_FETCH:  if (imem_ack_i) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_halt)     w_next = S_HALT;
        else if (w_is_mul) w_next = S_MUL;
        else               w_next = S_EXEC;
      end
      S_EXEC:   w_next = S_WB;
      S_MUL:    if (r_cnt == CNT_W'(DATA_W - 1)) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_wb_en     = (r_state == S_WB) && w_supported && (w_dest != '0);
  assign imem_req_o  = (r_state == S_FETCH);
  assign imem_addr_o = r_pc;
  assign busy_o      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halt_o      = (r_state == S_HALT);
  assign wb_en_o     = w_wb_en;
  assign wb_addr_o   = w_wb_en ? w_dest : '0;
  assign wb_data_o   = w_wb_en ? r_acc : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_inst   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: if (imem_ack_i) r_inst <= imem_data_i;
        S_DECODE: begin
          r_acc    <= '0;
          r_mcand  <= w_rs_val;
          r_mplier <= w_rt_val;
          r_cnt    <= '0;
        end
        S_EXEC: r_acc <= w_alu;
        S_MUL: begin
          // One multiplier bit per cycle, LSB first
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_WB: begin
          if (w_wb_en) r_regs[w_dest] <= r_acc;
          r_pc <= r_pc + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width; legal 16..32.
REQ-002 Parameter ADDR_W, default 32, PC and instruction-address width.
REQ-003 Parameter NREG, default 32, register count; power of two, 8..32; RA_W = log2(NREG).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  begin execution from PC 0; sampled only in IDLE.
REQ-007 imem_req_o  out  1  instruction fetch request.
REQ-008 imem_addr_o  out  ADDR_W  fetch byte address (current PC).
REQ-009 imem_ack_i  in  1  fetch data valid this cycle.
REQ-010 imem_data_i  in  32  instruction word, qualified by imem_ack_i.
REQ-011 busy_o  out  1  high in every state except IDLE and HALT.
REQ-012 halt_o  out  1  high in HALT.
REQ-013 wb_en_o  out  1  one-cycle pulse on each register-file write.
REQ-014 wb_addr_o  out  RA_W  register written; wb_data_o  out  DATA_W  value written.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MUL, WB, HALT; one state per cycle unless stated.
REQ-016 IDLE: start_i=1 -> FETCH; otherwise stay.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=PC, both held stable until imem_ack_i=1; on ack latch imem_data_i, -> DECODE; no timeout.
REQ-018 DECODE: read rs=inst[25:21], rt=inst[20:16] (low RA_W bits of each field), sign-extend inst[15:0] to DATA_W.
REQ-019 DECODE routing: op=6'h3F -> HALT; op=0 with funct=6'h18 -> MUL; all else -> EXEC.
REQ-020 Supported ops: op=0 funct 6'h20 add, 6'h22 sub, 6'h24 and, 6'h25 or, dest rd=inst[15:11]; op=6'h08 addi, dest rt; op=0 funct 6'h18 mul, dest rd.
REQ-021 Unsupported opcode/funct: no register write, PC still advances by 4.
REQ-022 EXEC: one cycle, result = rs op (rt or imm), modulo 2^DATA_W, no overflow detection, -> WB.
REQ-023 MUL: iterative shift-add, one multiplier bit per cycle, exactly DATA_W cycles, result = low DATA_W bits of rs*rt (unsigned), -> WB.
REQ-024 WB: write result when op supported and dest != 0; wb_en_o pulses in this cycle only; PC <= PC+4 modulo 2^ADDR_W; -> FETCH.
REQ-025 Register 0 reads 0 always; writes to it suppressed and wb_en_o stays low.
REQ-026 Register reads in DECODE return values from prior WB (no bypass needed; multi-cycle).
REQ-027 Latency with zero-wait ack: non-mul instruction 4 cycles FETCH-to-next-FETCH; mul 3+DATA_W cycles.
REQ-028 HALT: terminal; start_i ignored; imem_req_o=0; left only by reset.
REQ-029 start_i while busy or halted has no effect.
REQ-030 imem_ack_i outside FETCH is ignored.

Reset
REQ-031 rst_i=0 at a clock edge: state=IDLE, PC=0, all registers=0, MUL counter=0, instruction latch=0.
REQ-032 Reset-state outputs: imem_req_o=0, imem_addr_o=0, busy_o=0, halt_o=0, wb_en_o=0, wb_addr_o=0, wb_data_o=0.
REQ-033 Reset mid-FETCH, mid-MUL or in WB aborts the instruction; no register write occurs in the reset cycle.

Verification
REQ-034 Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt, zero-wait ack -> wb events (1,5),(2,0xFFFFFFFD),(3,2); halt_o after 13 cycles from first FETCH.
REQ-035 r1=7, r2=6, mul r3,r1,r2 -> wb (3,42) exactly 3+DATA_W cycles after FETCH ack; busy_o high throughout.
REQ-036 Ack delayed 3 cycles -> imem_req_o and imem_addr_o held constant for 4 cycles; execution result unchanged.
REQ-037 addi r0,r0,9 then sub r4,r0,r0 and illegal op 6'h3E -> no wb_en_o for r0 or illegal op, wb (4,0), PC advances 4 per instruction.
REQ-038 Assert rst_i=0 during MUL cycle 10 -> next cycle busy_o=0, PC=0, no wb; start_i then restarts from address 0.
REQ-039 NREG=8, DATA_W=16: add r9 writes r1 (field low bits); 0x7FFF+1 -> 0x8000, no trap.
